mipi_rx_frame_checker: RTL and testbench

//  Receive-side partner of the loopback pattern transmitter. Sits on the parallel output of the MIPI RX

---
 rtl/mipi_rx_frame_checker_pkg.sv | 24 ++
 rtl/mipi_rx_frame_checker_if.sv | 26 ++
 rtl/mipi_rx_pattern_ref.sv | 31 +++
 rtl/mipi_rx_frame_checker.sv | 193 +++++++++++++++++++
 tb/tb_mipi_rx_frame_checker.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_frame_checker_pkg.sv
// Shared constants and types for the MIPI RX loopback frame checker.
// The pattern values, data type and default geometry match the loopback
// TX pattern generator so both ends of the link agree on the window rule.
package mipi_rx_frame_checker_pkg;

    localparam int          H_ACTIVE_DEF   = 640;
    localparam int          V_ACTIVE_DEF   = 480;
    localparam int          WIN_MARGIN_DEF = 100;
    localparam int          FLASH_W_DEF    = 25;

    localparam logic [47:0] PIX_IN   = 48'h204f4c4c4548;
    localparam logic [47:0] PIX_OUT  = 48'hFF00FFFF00FF;
    localparam logic [5:0]  EXP_TYPE = 6'h24;

    // x saturates at H_ACTIVE, y saturates at 2047
    localparam int          X_W = 10;
    localparam int          Y_W = 11;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        ACTIVE    = 1'b1
    } chk_state_e;

endpackage

// File: rtl/mipi_rx_frame_checker_if.sv
// Parallel output bus of the MIPI RX hard block (VC0).
//   my_mipi_rx_VALID : data beat valid
//   my_mipi_rx_HSYNC : line sync
//   my_mipi_rx_VSYNC : frame sync
//   my_mipi_rx_DATA  : beat data, [63:48] unused by the checker
//   my_mipi_rx_TYPE  : packet data type
// Handshake: there is no backpressure. A beat is transferred on every
// rising clock edge at which VALID is high; the receiver must accept it.
// master = the RX block (or a bench driving it), slave = the checker.
interface mipi_rx_frame_checker_if;
    logic        my_mipi_rx_VALID;
    logic        my_mipi_rx_HSYNC;
    logic        my_mipi_rx_VSYNC;
    logic [63:0] my_mipi_rx_DATA;
    logic [5:0]  my_mipi_rx_TYPE;

    modport master (
        output my_mipi_rx_VALID, my_mipi_rx_HSYNC, my_mipi_rx_VSYNC,
               my_mipi_rx_DATA, my_mipi_rx_TYPE
    );

    modport slave (
        input  my_mipi_rx_VALID, my_mipi_rx_HSYNC, my_mipi_rx_VSYNC,
               my_mipi_rx_DATA, my_mipi_rx_TYPE
    );
endinterface

// File: rtl/mipi_rx_pattern_ref.sv
// Combinational reference of the TX window pattern.
//   x_i   : beat index within the line
//   y_i   : line index within the frame
//   pix_o : expected DATA[47:0] for that position
// Inside the window (strict bounds on both axes) the pattern is PIX_IN,
// everywhere else PIX_OUT.
module mipi_rx_pattern_ref
    import mipi_rx_frame_checker_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int WIN_MARGIN = WIN_MARGIN_DEF
) (
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    output logic [47:0]    pix_o
);

    localparam logic [X_W-1:0] X_LO = X_W'(WIN_MARGIN);
    localparam logic [X_W-1:0] X_HI = X_W'(H_ACTIVE - WIN_MARGIN);
    localparam logic [Y_W-1:0] Y_LO = Y_W'(WIN_MARGIN);
    localparam logic [Y_W-1:0] Y_HI = Y_W'(V_ACTIVE - WIN_MARGIN);

    logic in_win;

    always_comb begin
        in_win = (x_i > X_LO) && (x_i < X_HI) && (y_i > Y_LO) && (y_i < Y_HI);
        pix_o  = in_win ? PIX_IN : PIX_OUT;
    end

endmodule

// File: rtl/mipi_rx_frame_checker.sv
// Receive-side checker for the MIPI loopback pattern.
// Rebuilds frame/line position from VSYNC/HSYNC/VALID, compares each beat
// against the TX window pattern, checks frame geometry and drives status.
//   rx_pixel_clk : sole clock
//   rst          : asynchronous active-high reset
//   rx_if        : RX parallel bus (slave)
//   frame_cnt    : completed frames, wraps
//   err_cnt      : mismatching beats, saturates at 16'hFFFF
//   last_lines   : line count of last completed frame
//   frame_ok     : last completed frame clean with correct geometry
//   err_sticky   : any mismatch since reset
//   led_pass     : flashing while frame_ok and no error seen
//   led_fail     : err_sticky
//   state_o      : checker FSM state
module mipi_rx_frame_checker
    import mipi_rx_frame_checker_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int WIN_MARGIN = WIN_MARGIN_DEF,
    parameter int FLASH_W    = FLASH_W_DEF
) (
    input  logic                   rx_pixel_clk,
    input  logic                   rst,
    mipi_rx_frame_checker_if.slave rx_if,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            err_cnt,
    output logic [10:0]            last_lines,
    output logic                   frame_ok,
    output logic                   err_sticky,
    output logic                   led_pass,
    output logic                   led_fail,
    output chk_state_e             state_o
);

    localparam logic [X_W-1:0] X_FULL = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_FULL = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_MAX  = '1;

    // Stage 1 input registers and their previous values for edge detect
    logic        valid_q, hsync_q, vsync_q;
    logic        valid_p_q, hsync_p_q, vsync_p_q;
    logic [47:0] data_q;
    logic [5:0]  type_q;

    chk_state_e           state_q;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic                 line_bad_q, line_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 mismatch_q, mismatch_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [10:0]          last_lines_q, last_lines_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 err_sticky_q;
    logic [FLASH_W-1:0]   flash_q;

    logic           vsync_rise, hsync_rise, valid_fall;
    logic           live, frame_end, line_open;
    logic [X_W-1:0] beat_x;
    logic [Y_W-1:0] beat_y;
    logic [47:0]    exp_pix;
    logic           unused_data_hi;

    assign unused_data_hi = ^rx_if.my_mipi_rx_DATA[63:48];

    assign vsync_rise = vsync_q & ~vsync_p_q;
    assign hsync_rise = hsync_q & ~hsync_p_q;
    assign valid_fall = valid_p_q & ~valid_q;
    // The VSYNC rise that leaves SYNC_WAIT already starts a real frame
    assign live       = (state_q == ACTIVE) | vsync_rise;
    assign frame_end  = (state_q == ACTIVE) & vsync_rise;
    assign line_open  = valid_p_q & valid_q;

    // A beat arriving with the VSYNC rise belongs to the new frame at (0,0)
    assign beat_x = vsync_rise ? '0 : x_q;
    assign beat_y = vsync_rise ? '0 : y_q;

    mipi_rx_pattern_ref #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .WIN_MARGIN (WIN_MARGIN)
    ) u_ref (
        .x_i   (beat_x),
        .y_i   (beat_y),
        .pix_o (exp_pix)
    );

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        line_bad_d   = line_bad_q;
        // mismatch_q always belongs to a beat of the frame currently open
        frame_err_d  = frame_err_q | mismatch_q;
        frame_cnt_d  = frame_cnt_q;
        last_lines_d = last_lines_q;
        frame_ok_d   = frame_ok_q;
        mismatch_d   = 1'b0;

        // Line end is applied before a same-cycle frame end so the line counts
        if (live && valid_fall) begin
            line_bad_d = line_bad_d | (x_q != X_FULL);
            y_d        = (y_q == Y_MAX) ? y_q : y_q + 1'b1;
            x_d        = '0;
        end

        if (live && hsync_rise && valid_q && (x_q != '0)) begin
            line_bad_d = 1'b1;
        end

        if (vsync_rise) begin
            if (frame_end) begin
                frame_cnt_d  = frame_cnt_q + 16'd1;
                last_lines_d = y_d;
                frame_ok_d   = ~frame_err_d & ~line_bad_d & (y_d == Y_FULL) & ~line_open;
            end
            x_d         = '0;
            y_d         = '0;
            line_bad_d  = 1'b0;
            frame_err_d = 1'b0;
        end

        if (live && valid_q) begin
            if (beat_x == X_FULL) begin
                line_bad_d = 1'b1;
            end else begin
                x_d = beat_x + 1'b1;
            end
            mismatch_d = (data_q != exp_pix) | (type_q != EXP_TYPE);
        end

        err_cnt_d = (mismatch_q && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            valid_p_q    <= 1'b0;
            hsync_p_q    <= 1'b0;
            vsync_p_q    <= 1'b0;
            data_q       <= '0;
            type_q       <= '0;
            state_q      <= SYNC_WAIT;
            x_q          <= '0;
            y_q          <= '0;
            line_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            last_lines_q <= '0;
            frame_ok_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            flash_q      <= '0;
        end else begin
            valid_q      <= rx_if.my_mipi_rx_VALID;
            hsync_q      <= rx_if.my_mipi_rx_HSYNC;
            vsync_q      <= rx_if.my_mipi_rx_VSYNC;
            data_q       <= rx_if.my_mipi_rx_DATA[47:0];
            type_q       <= rx_if.my_mipi_rx_TYPE;
            valid_p_q    <= valid_q;
            hsync_p_q    <= hsync_q;
            vsync_p_q    <= vsync_q;
            if (vsync_rise) begin
                state_q <= ACTIVE;
            end
            x_q          <= x_d;
            y_q          <= y_d;
            line_bad_q   <= line_bad_d;
            frame_err_q  <= frame_err_d;
            mismatch_q   <= mismatch_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            last_lines_q <= last_lines_d;
            frame_ok_q   <= frame_ok_d;
            err_sticky_q <= err_sticky_q | mismatch_q;
            flash_q      <= flash_q + 1'b1;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign last_lines = last_lines_q;
    assign frame_ok   = frame_ok_q;
    assign err_sticky = err_sticky_q;
    assign led_fail   = err_sticky_q;
    assign led_pass   = flash_q[FLASH_W-1] & frame_ok_q & ~err_sticky_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mipi_rx_frame_checker.sv
// Bench for mipi_rx_frame_checker on a reduced 16x12 geometry (margin 4).
module tb_mipi_rx_frame_checker;
    import mipi_rx_frame_checker_pkg::*;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int M  = 4;
    localparam int FW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mipi_rx_frame_checker_if bus();

    logic [15:0] frame_cnt, err_cnt;
    logic [10:0] last_lines;
    logic        frame_ok, err_sticky, led_pass, led_fail;
    chk_state_e  state_dbg;

    mipi_rx_frame_checker #(
        .H_ACTIVE (H), .V_ACTIVE (V), .WIN_MARGIN (M), .FLASH_W (FW)
    ) dut (
        .rx_pixel_clk (clk),
        .rst          (rst),
        .rx_if        (bus),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .last_lines   (last_lines),
        .frame_ok     (frame_ok),
        .err_sticky   (err_sticky),
        .led_pass     (led_pass),
        .led_fail     (led_fail),
        .state_o      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] ref_pix(input int x, input int y);
        return (x > M && x < H - M && y > M && y < V - M) ? PIX_IN : PIX_OUT;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic hs, input logic vs,
                         input logic [47:0] d, input logic [5:0] t);
        @(negedge clk);
        bus.my_mipi_rx_VALID = v;
        bus.my_mipi_rx_HSYNC = hs;
        bus.my_mipi_rx_VSYNC = vs;
        bus.my_mipi_rx_DATA  = {16'($urandom_range(0, 65535)), d};
        bus.my_mipi_rx_TYPE  = t;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 48'h0, 6'h0);
    endtask

    task automatic vsync_pulse();
        drive(1'b0, 1'b0, 1'b1, 48'h0, 6'h0);
        idle(3);
    endtask

    typedef struct {
        int          bad_x;
        int          bad_y;
        logic [47:0] bad_d;
        logic [5:0]  bad_t;
        int          short_y;
        int          hs_y;
        int          err_inc;
        logic        ok;
    } vec_t;

    task automatic frame_body(input vec_t vv, input int nlines);
        for (int y = 0; y < nlines; y++) begin
            drive(1'b0, 1'b1, 1'b0, 48'h0, 6'h0);
            idle(1);
            for (int x = 0; x < ((y == vv.short_y) ? H - 1 : H); x++) begin
                logic [47:0] d;
                logic [5:0]  t;
                logic        hs;
                d  = ref_pix(x, y);
                t  = EXP_TYPE;
                hs = (y == vv.hs_y) && (x == 5);
                if (x == vv.bad_x && y == vv.bad_y) begin
                    d = vv.bad_d;
                    t = vv.bad_t;
                end
                drive(1'b1, hs, 1'b0, d, t);
            end
            idle(2);
        end
    endtask

    vec_t vecs[9];
    vec_t clean;

    initial begin
        int   exp_err;
        int   exp_frames;
        logic sticky;
        logic seen0, seen1;

        clean = '{-1, -1, PIX_OUT, EXP_TYPE, -1, -1, 0, 1'b1};
        vecs[0] = clean;
        vecs[1] = clean;
        vecs[2] = '{8, 6, 48'h0,   EXP_TYPE, -1, -1, 1, 1'b0};  // inside window zeroed
        vecs[3] = '{-1, -1, PIX_OUT, EXP_TYPE, 10, -1, 0, 1'b0}; // short line
        vecs[4] = '{4, 6, PIX_IN,  EXP_TYPE, -1, -1, 1, 1'b0};  // x=margin is outside
        vecs[5] = '{5, 6, PIX_OUT, EXP_TYPE, -1, -1, 1, 1'b0};  // x=margin+1 is inside
        vecs[6] = '{2, 1, PIX_OUT, 6'h2A,    -1, -1, 1, 1'b0};  // bad type only
        vecs[7] = '{-1, -1, PIX_OUT, EXP_TYPE, -1, 3, 0, 1'b0}; // HSYNC mid-line
        vecs[8] = clean;

        bus.my_mipi_rx_VALID = 1'b0;
        bus.my_mipi_rx_HSYNC = 1'b0;
        bus.my_mipi_rx_VSYNC = 1'b0;
        bus.my_mipi_rx_DATA  = '0;
        bus.my_mipi_rx_TYPE  = '0;

        // Reset state
        idle(3);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_last_lines", last_lines, 0);
        check("rst_flags", {frame_ok, err_sticky, led_pass, led_fail}, 0);
        check("rst_state", state_dbg, SYNC_WAIT);
        rst = 1'b0;

        // Beats before the first VSYNC are ignored
        repeat (4) drive(1'b1, 1'b0, 1'b0, 48'h0, 6'h0);
        idle(4);
        check("presync_err_cnt", err_cnt, 0);

        vsync_pulse();
        check("sync_state", state_dbg, ACTIVE);
        check("sync_frame_cnt", frame_cnt, 0);

        // ---------------- table-driven frames ----------------
        exp_err    = 0;
        exp_frames = 0;
        sticky     = 1'b0;
        for (int i = 0; i < 9; i++) begin
            frame_body(vecs[i], V);
            vsync_pulse();
            exp_err    += vecs[i].err_inc;
            exp_frames += 1;
            sticky      = sticky | (vecs[i].err_inc != 0);
            check($sformatf("v%0d_frame_cnt", i), frame_cnt, exp_frames);
            check($sformatf("v%0d_err_cnt", i), err_cnt, exp_err);
            check($sformatf("v%0d_frame_ok", i), frame_ok, vecs[i].ok);
            check($sformatf("v%0d_last_lines", i), last_lines, V);
            check($sformatf("v%0d_sticky", i), {err_sticky, led_fail}, {sticky, sticky});
            seen0 = 1'b0;
            seen1 = 1'b0;
            for (int c = 0; c < 16; c++) begin
                idle(1);
                if (led_pass) seen1 = 1'b1; else seen0 = 1'b1;
            end
            check($sformatf("v%0d_led_pass", i), {seen1, seen0},
                  (vecs[i].ok && !sticky) ? 2'b11 : 2'b01);
        end

        // ---------------- err_cnt latency ----------------
        drive(1'b1, 1'b0, 1'b0, 48'h0, EXP_TYPE);
        idle(1);
        check("lat_cycle1", err_cnt, exp_err);
        idle(1);
        check("lat_cycle2", err_cnt, exp_err);
        idle(1);
        check("lat_cycle3", err_cnt, exp_err + 1);
        exp_err++;

        // ---------------- VSYNC rise together with a beat ----------------
        vsync_pulse();
        exp_frames++;
        frame_body(clean, 6);
        for (int x = 0; x < 6; x++) drive(1'b1, 1'b0, 1'b0, ref_pix(x, 6), EXP_TYPE);
        // With the old position (6,6) this beat would need PIX_IN
        drive(1'b1, 1'b0, 1'b1, PIX_OUT, EXP_TYPE);
        exp_frames++;
        drive(1'b1, 1'b0, 1'b0, PIX_OUT, EXP_TYPE);
        idle(4);
        check("simul_frame_cnt", frame_cnt, exp_frames);
        check("simul_last_lines", last_lines, 6);
        check("simul_err_cnt", err_cnt, exp_err);

        // ---------------- frame end during an open line ----------------
        vsync_pulse();
        exp_frames++;
        frame_body(clean, V);
        for (int x = 0; x < 6; x++) drive(1'b1, 1'b0, 1'b0, PIX_OUT, EXP_TYPE);
        drive(1'b1, 1'b0, 1'b1, PIX_OUT, EXP_TYPE);
        exp_frames++;
        idle(4);
        check("open_frame_cnt", frame_cnt, exp_frames);
        check("open_last_lines", last_lines, V);
        check("open_frame_ok", frame_ok, 0);
        check("open_err_cnt", err_cnt, exp_err);

        // ---------------- reset mid-frame ----------------
        vsync_pulse();
        frame_body(clean, 6);
        drive(1'b1, 1'b0, 1'b0, PIX_OUT, EXP_TYPE);
        rst = 1'b1;
        #1;
        check("midrst_counts", {frame_cnt, err_cnt}, 0);
        check("midrst_flags", {last_lines, frame_ok, err_sticky, led_fail, led_pass}, 0);
        check("midrst_state", state_dbg, SYNC_WAIT);
        idle(2);
        rst = 1'b0;
        vsync_pulse();
        frame_body(clean, V);
        vsync_pulse();
        frame_body(clean, V);
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_ok", {frame_ok, err_sticky}, 2'b10);

        // ---------------- err_cnt saturation ----------------
        for (int n = 0; n < 65540; n++) drive(1'b1, 1'b0, 1'b0, 48'h0, EXP_TYPE);
        idle(4);
        check("sat_err_cnt", err_cnt, 16'hFFFF);
        check("sat_sticky", {err_sticky, led_fail, led_pass}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: stimulus is bounded, but never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
